// File: rtl/gmp_demapper_if.sv
// Deframer-to-demapper bundle: frame parameters and payload slots in, extracted data and status out.
// The master side is the deframer/client pair, the slave side is the demapper.
interface gmp_demapper_if #(
   parameter int MPT_W  = 8,
   parameter int DATA_W = 8
);
   logic [MPT_W-1:0]  pm;
   logic [MPT_W-1:0]  cm;
   logic              sof;
   logic              valid_in;
   logic [DATA_W-1:0] data_in;
   logic              ds_in;
   logic [DATA_W-1:0] data_out;
   logic              data_valid;
   logic              sof_out;
   logic              eof_out;
   logic [MPT_W-1:0]  data_cnt;
   logic              input_err;
   logic              ds_mismatch;
   logic              err_sof_early;
   logic              err_sof_late;

   modport master (
      output pm, cm, sof, valid_in, data_in, ds_in,
      input  data_out, data_valid, sof_out, eof_out, data_cnt,
             input_err, ds_mismatch, err_sof_early, err_sof_late
   );

   modport slave (
      input  pm, cm, sof, valid_in, data_in, ds_in,
      output data_out, data_valid, sof_out, eof_out, data_cnt,
             input_err, ds_mismatch, err_sof_early, err_sof_late
   );
endinterface

// File: rtl/gmp_demapper.sv
// GMP demapper: regenerates the per-slot data/stuff decision from Pm/Cm, strips stuff words,
// and flags far-end indicator disagreements and framing errors. All outputs registered.
module gmp_demapper #(
   parameter int MPT_W  = 8,
   parameter int DATA_W = 8
) (
   input logic            clk,
   input logic            rst,
   gmp_demapper_if.slave  bus
);
   typedef enum logic {IDLE, RUN} state_t;

   state_t            r_state, w_stateNext;
   logic [MPT_W-1:0]  r_pm, w_pmNext;
   logic [MPT_W-1:0]  r_cm, w_cmNext;
   logic [MPT_W-1:0]  r_acc, w_accNext;
   logic [MPT_W-1:0]  r_slot, w_slotNext;
   logic [MPT_W-1:0]  r_cnt, w_cntNext;
   logic [DATA_W-1:0] r_dataOut, w_dataOutNext;
   logic              r_dataValid, w_dataValidNext;
   logic              r_sofOut, w_sofOutNext;
   logic              r_eofOut, w_eofOutNext;
   logic [MPT_W-1:0]  r_dataCnt, w_dataCntNext;
   logic              r_inputErr, w_inputErrNext;
   logic              r_dsMismatch, w_dsMismatchNext;
   logic              r_errEarly, w_errEarlyNext;
   logic              r_errLate, w_errLateNext;

   logic [MPT_W:0]    w_sum;
   logic              w_wrap;
   logic [MPT_W-1:0]  w_accStep;
   logic [MPT_W-1:0]  w_slotInc;
   logic [MPT_W-1:0]  w_cntInc;

   // acc stays below pm, so the modular MPT_W-bit subtraction yields the exact remainder.
   assign w_sum     = {1'b0, r_acc} + {1'b0, r_cm};
   assign w_wrap    = (w_sum >= {1'b0, r_pm});
   assign w_accStep = w_wrap ? (r_acc + r_cm - r_pm) : (r_acc + r_cm);
   assign w_slotInc = r_slot + 1'b1;
   assign w_cntInc  = r_cnt + {{(MPT_W-1){1'b0}}, w_wrap};

   always_comb begin
      w_stateNext      = r_state;
      w_pmNext         = r_pm;
      w_cmNext         = r_cm;
      w_accNext        = r_acc;
      w_slotNext       = r_slot;
      w_cntNext        = r_cnt;
      w_dataOutNext    = r_dataOut;
      w_dataValidNext  = 1'b0;
      w_sofOutNext     = 1'b0;
      w_eofOutNext     = 1'b0;
      w_dataCntNext    = r_dataCnt;
      w_inputErrNext   = r_inputErr;
      w_dsMismatchNext = 1'b0;
      w_errEarlyNext   = 1'b0;
      w_errLateNext    = 1'b0;

      if (bus.sof) begin
         w_pmNext       = bus.pm;
         w_cmNext       = bus.cm;
         w_accNext      = '0;
         w_slotNext     = '0;
         w_cntNext      = '0;
         w_sofOutNext   = 1'b1;
         w_errEarlyNext = (r_state == RUN);
         if ((bus.pm != '0) && (bus.cm <= bus.pm)) begin
            w_stateNext    = RUN;
            w_inputErrNext = 1'b0;
         end else begin
            w_stateNext    = IDLE;
            w_inputErrNext = 1'b1;
         end
      end else if (bus.valid_in) begin
         if (r_state == IDLE) begin
            w_errLateNext = 1'b1;
         end else begin
            w_accNext        = w_accStep;
            w_slotNext       = w_slotInc;
            w_cntNext        = w_cntInc;
            w_dsMismatchNext = (bus.ds_in != w_wrap);
            if (w_wrap) begin
               w_dataOutNext   = bus.data_in;
               w_dataValidNext = 1'b1;
            end
            if (w_slotInc == r_pm) begin
               w_eofOutNext  = 1'b1;
               w_dataCntNext = w_cntInc;
               w_stateNext   = IDLE;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= IDLE;
         r_pm         <= '0;
         r_cm         <= '0;
         r_acc        <= '0;
         r_slot       <= '0;
         r_cnt        <= '0;
         r_dataOut    <= '0;
         r_dataValid  <= 1'b0;
         r_sofOut     <= 1'b0;
         r_eofOut     <= 1'b0;
         r_dataCnt    <= '0;
         r_inputErr   <= 1'b0;
         r_dsMismatch <= 1'b0;
         r_errEarly   <= 1'b0;
         r_errLate    <= 1'b0;
      end else begin
         r_state      <= w_stateNext;
         r_pm         <= w_pmNext;
         r_cm         <= w_cmNext;
         r_acc        <= w_accNext;
         r_slot       <= w_slotNext;
         r_cnt        <= w_cntNext;
         r_dataOut    <= w_dataOutNext;
         r_dataValid  <= w_dataValidNext;
         r_sofOut     <= w_sofOutNext;
         r_eofOut     <= w_eofOutNext;
         r_dataCnt    <= w_dataCntNext;
         r_inputErr   <= w_inputErrNext;
         r_dsMismatch <= w_dsMismatchNext;
         r_errEarly   <= w_errEarlyNext;
         r_errLate    <= w_errLateNext;
      end
   end

   assign bus.data_out      = r_dataOut;
   assign bus.data_valid    = r_dataValid;
   assign bus.sof_out       = r_sofOut;
   assign bus.eof_out       = r_eofOut;
   assign bus.data_cnt      = r_dataCnt;
   assign bus.input_err     = r_inputErr;
   assign bus.ds_mismatch   = r_dsMismatch;
   assign bus.err_sof_early = r_errEarly;
   assign bus.err_sof_late  = r_errLate;
endmodule

// File: tb/tb_gmp_demapper.sv
// Self-checking bench for gmp_demapper: expected data words are queued as slots are driven
// and popped when data_valid appears; each scenario task checks its own pulses and counts.
module tb_gmp_demapper;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   logic [7:0] expData[$];

   gmp_demapper_if #(.MPT_W(8), .DATA_W(8)) bus ();

   gmp_demapper #(.MPT_W(8), .DATA_W(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Reference decision: slot j carries data iff (j*Cm mod Pm) < Cm.
   function automatic logic isData(input int j, input int pm, input int cm);
      return ((j * cm) % pm) < cm;
   endfunction

   task automatic driveSof(input int pm, input int cm);
      @(negedge clk);
      bus.sof      = 1'b1;
      bus.valid_in = 1'b0;
      bus.pm       = pm[7:0];
      bus.cm       = cm[7:0];
      @(posedge clk);
      #1;
      bus.sof = 1'b0;
   endtask

   task automatic driveSlot(input int j, input int pm, input int cm, input logic ds);
      @(negedge clk);
      bus.valid_in = 1'b1;
      bus.data_in  = j[7:0];
      bus.ds_in    = ds;
      if (isData(j, pm, cm)) expData.push_back(j[7:0]);
      @(posedge clk);
      #1;
      bus.valid_in = 1'b0;
   endtask

   task automatic test_reset;
      bus.sof = 1'b0; bus.valid_in = 1'b0; bus.pm = '0; bus.cm = '0;
      bus.data_in = '0; bus.ds_in = 1'b0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({bus.data_out, bus.data_valid, bus.sof_out, bus.eof_out, bus.data_cnt, bus.input_err,
           bus.ds_mismatch, bus.err_sof_early, bus.err_sof_late} !== 25'd0) begin
         errors++;
         $display("[TB] FAIL reset_outputs got valid=%b sof=%b eof=%b cnt=%0d err=%b want all zero",
                  bus.data_valid, bus.sof_out, bus.eof_out, bus.data_cnt, bus.input_err);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_basic;
      logic [7:0] e;
      driveSof(8, 3);
      checks++;
      if ({bus.sof_out, bus.input_err, bus.err_sof_early} !== 3'b100) begin
         errors++;
         $display("[TB] FAIL basic_sof got sof/inerr/early=%b%b%b want 100",
                  bus.sof_out, bus.input_err, bus.err_sof_early);
      end
      for (int j = 1; j <= 8; j++) begin
         driveSlot(j, 8, 3, isData(j, 8, 3));
         checks++;
         if (bus.data_valid !== isData(j, 8, 3)) begin
            errors++;
            $display("[TB] FAIL basic_valid slot %0d got %b want %b", j, bus.data_valid, isData(j, 8, 3));
         end
         if (bus.data_valid === 1'b1) begin
            checks++;
            if (expData.size() == 0) begin
               errors++;
               $display("[TB] FAIL basic_data slot %0d got %0d want nothing", j, bus.data_out);
            end else begin
               e = expData.pop_front();
               if (bus.data_out !== e) begin
                  errors++;
                  $display("[TB] FAIL basic_data slot %0d got %0d want %0d", j, bus.data_out, e);
               end
            end
         end
         checks++;
         if ({bus.eof_out, bus.ds_mismatch, bus.err_sof_early, bus.err_sof_late} !== {j == 8, 3'b000}) begin
            errors++;
            $display("[TB] FAIL basic_flags slot %0d got eof/dsm/early/late=%b%b%b%b want %b000",
                     j, bus.eof_out, bus.ds_mismatch, bus.err_sof_early, bus.err_sof_late, j == 8);
         end
      end
      checks++;
      if (bus.data_cnt !== 8'd3) begin
         errors++;
         $display("[TB] FAIL basic_cnt got %0d want 3", bus.data_cnt);
      end
      checks++;
      if (expData.size() != 0) begin
         errors++;
         $display("[TB] FAIL basic_leftover got %0d queued want 0", expData.size());
      end
      expData.delete();
   endtask

   task automatic test_back_to_back;
      logic [7:0] e;
      for (int f = 0; f < 2; f++) begin
         int cm = (f == 0) ? 5 : 0;
         driveSof(5, cm);
         checks++;
         if ({bus.sof_out, bus.err_sof_early, bus.input_err} !== 3'b100) begin
            errors++;
            $display("[TB] FAIL b2b_sof frame %0d got sof/early/inerr=%b%b%b want 100",
                     f, bus.sof_out, bus.err_sof_early, bus.input_err);
         end
         for (int j = 1; j <= 5; j++) begin
            driveSlot(j, 5, cm, isData(j, 5, cm));
            checks++;
            if ({bus.data_valid, bus.eof_out, bus.ds_mismatch} !== {isData(j, 5, cm), j == 5, 1'b0}) begin
               errors++;
               $display("[TB] FAIL b2b_flags frame %0d slot %0d got valid/eof/dsm=%b%b%b want %b%b0",
                        f, j, bus.data_valid, bus.eof_out, bus.ds_mismatch, isData(j, 5, cm), j == 5);
            end
            if (bus.data_valid === 1'b1) begin
               checks++;
               e = (expData.size() != 0) ? expData.pop_front() : 8'hxx;
               if (bus.data_out !== e) begin
                  errors++;
                  $display("[TB] FAIL b2b_data frame %0d slot %0d got %0d want %0d", f, j, bus.data_out, e);
               end
            end
         end
         checks++;
         if (bus.data_cnt !== cm[7:0]) begin
            errors++;
            $display("[TB] FAIL b2b_cnt frame %0d got %0d want %0d", f, bus.data_cnt, cm);
         end
      end
      checks++;
      if (expData.size() != 0) begin
         errors++;
         $display("[TB] FAIL b2b_leftover got %0d queued want 0", expData.size());
      end
      expData.delete();
   endtask

   task automatic test_ds_mismatch;
      logic [7:0] e;
      driveSof(8, 3);
      for (int j = 1; j <= 8; j++) begin
         driveSlot(j, 8, 3, (j == 2) ? 1'b1 : isData(j, 8, 3));
         checks++;
         if ({bus.ds_mismatch, bus.data_valid} !== {j == 2, isData(j, 8, 3)}) begin
            errors++;
            $display("[TB] FAIL ds_flags slot %0d got dsm/valid=%b%b want %b%b",
                     j, bus.ds_mismatch, bus.data_valid, j == 2, isData(j, 8, 3));
         end
         if (bus.data_valid === 1'b1) begin
            checks++;
            e = (expData.size() != 0) ? expData.pop_front() : 8'hxx;
            if (bus.data_out !== e) begin
               errors++;
               $display("[TB] FAIL ds_data slot %0d got %0d want %0d", j, bus.data_out, e);
            end
         end
      end
      checks++;
      if ({bus.eof_out, bus.data_cnt} !== {1'b1, 8'd3}) begin
         errors++;
         $display("[TB] FAIL ds_eof got eof=%b cnt=%0d want eof=1 cnt=3", bus.eof_out, bus.data_cnt);
      end
      expData.delete();
   endtask

   task automatic test_sof_early;
      logic [7:0] e;
      driveSof(8, 3);
      for (int j = 1; j <= 4; j++) begin
         driveSlot(j, 8, 3, isData(j, 8, 3));
         checks++;
         if (bus.eof_out !== 1'b0) begin
            errors++;
            $display("[TB] FAIL early_noeof slot %0d got %b want 0", j, bus.eof_out);
         end
         if (bus.data_valid === 1'b1) void'(expData.pop_front());
      end
      driveSof(8, 3);
      checks++;
      if ({bus.err_sof_early, bus.sof_out, bus.eof_out} !== 3'b110) begin
         errors++;
         $display("[TB] FAIL early_sof got early/sof/eof=%b%b%b want 110",
                  bus.err_sof_early, bus.sof_out, bus.eof_out);
      end
      for (int j = 1; j <= 8; j++) begin
         driveSlot(j, 8, 3, isData(j, 8, 3));
         checks++;
         if ({bus.data_valid, bus.eof_out, bus.err_sof_early} !== {isData(j, 8, 3), j == 8, 1'b0}) begin
            errors++;
            $display("[TB] FAIL early_restart slot %0d got valid/eof/early=%b%b%b want %b%b0",
                     j, bus.data_valid, bus.eof_out, bus.err_sof_early, isData(j, 8, 3), j == 8);
         end
         if (bus.data_valid === 1'b1) begin
            checks++;
            e = (expData.size() != 0) ? expData.pop_front() : 8'hxx;
            if (bus.data_out !== e) begin
               errors++;
               $display("[TB] FAIL early_data slot %0d got %0d want %0d", j, bus.data_out, e);
            end
         end
      end
      checks++;
      if (bus.data_cnt !== 8'd3) begin
         errors++;
         $display("[TB] FAIL early_cnt got %0d want 3", bus.data_cnt);
      end
      expData.delete();
   endtask

   task automatic test_sof_late;
      driveSlot(9, 8, 0, 1'b0);
      checks++;
      if ({bus.err_sof_late, bus.data_valid} !== 2'b10) begin
         errors++;
         $display("[TB] FAIL late_first got late/valid=%b%b want 10", bus.err_sof_late, bus.data_valid);
      end
      driveSof(4, 6);
      checks++;
      if ({bus.input_err, bus.sof_out} !== 2'b11) begin
         errors++;
         $display("[TB] FAIL late_illegal got inerr/sof=%b%b want 11", bus.input_err, bus.sof_out);
      end
      driveSlot(9, 8, 0, 1'b1);
      checks++;
      if ({bus.err_sof_late, bus.data_valid, bus.input_err} !== 3'b101) begin
         errors++;
         $display("[TB] FAIL late_after_illegal got late/valid/inerr=%b%b%b want 101",
                  bus.err_sof_late, bus.data_valid, bus.input_err);
      end
      driveSof(1, 1);
      checks++;
      if (bus.input_err !== 1'b0) begin
         errors++;
         $display("[TB] FAIL late_inerr_clear got %b want 0", bus.input_err);
      end
      driveSlot(7, 1, 1, 1'b1);
      checks++;
      if ({bus.data_valid, bus.data_out, bus.eof_out, bus.data_cnt} !== {1'b1, 8'd7, 1'b1, 8'd1}) begin
         errors++;
         $display("[TB] FAIL late_pm1 got valid=%b data=%0d eof=%b cnt=%0d want 1 7 1 1",
                  bus.data_valid, bus.data_out, bus.eof_out, bus.data_cnt);
      end
      expData.delete();
   endtask

   task automatic test_reset_midframe;
      logic [7:0] e;
      driveSof(8, 3);
      driveSlot(1, 8, 3, 1'b0);
      driveSlot(2, 8, 3, 1'b0);
      @(negedge clk);
      bus.valid_in = 1'b1; bus.data_in = 8'd3; bus.ds_in = 1'b1;
      rst = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk);
         #1;
         bus.valid_in = 1'b0;
         checks++;
         if ({bus.data_out, bus.data_valid, bus.sof_out, bus.eof_out, bus.data_cnt, bus.input_err,
              bus.ds_mismatch, bus.err_sof_early, bus.err_sof_late} !== 25'd0) begin
            errors++;
            $display("[TB] FAIL midreset_outputs cycle %0d got data=%0d valid=%b eof=%b cnt=%0d want all zero",
                     c, bus.data_out, bus.data_valid, bus.eof_out, bus.data_cnt);
         end
      end
      @(negedge clk);
      rst = 1'b0;
      expData.delete();
      driveSlot(1, 8, 3, 1'b0);
      checks++;
      if ({bus.err_sof_late, bus.data_valid, bus.eof_out} !== 3'b100) begin
         errors++;
         $display("[TB] FAIL midreset_late got late/valid/eof=%b%b%b want 100",
                  bus.err_sof_late, bus.data_valid, bus.eof_out);
      end
      driveSof(8, 3);
      checks++;
      if ({bus.sof_out, bus.err_sof_early} !== 2'b10) begin
         errors++;
         $display("[TB] FAIL midreset_sof got sof/early=%b%b want 10", bus.sof_out, bus.err_sof_early);
      end
      for (int j = 1; j <= 8; j++) begin
         driveSlot(j, 8, 3, isData(j, 8, 3));
         checks++;
         if ({bus.data_valid, bus.eof_out, bus.ds_mismatch} !== {isData(j, 8, 3), j == 8, 1'b0}) begin
            errors++;
            $display("[TB] FAIL midreset_flags slot %0d got valid/eof/dsm=%b%b%b want %b%b0",
                     j, bus.data_valid, bus.eof_out, bus.ds_mismatch, isData(j, 8, 3), j == 8);
         end
         if (bus.data_valid === 1'b1) begin
            checks++;
            e = (expData.size() != 0) ? expData.pop_front() : 8'hxx;
            if (bus.data_out !== e) begin
               errors++;
               $display("[TB] FAIL midreset_data slot %0d got %0d want %0d", j, bus.data_out, e);
            end
         end
      end
      checks++;
      if (bus.data_cnt !== 8'd3) begin
         errors++;
         $display("[TB] FAIL midreset_cnt got %0d want 3", bus.data_cnt);
      end
      expData.delete();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_ds_mismatch();
      test_sof_early();
      test_sof_late();
      test_reset_midframe();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/gmp_demapper.md
# gmp_demapper

Receive-side counterpart of the stuff/data pattern generator. Per frame it regenerates the Generic Mapping Procedure (GMP) data/stuff decision from the frame's Pm and Cm. It uses that decision to strip stuff words from the incoming payload stream, passing only data words downstream, and checks the far-end data/stuff indicator and frame framing. It sits between the frame deframer (which supplies sof, Pm, Cm and payload words) and the client data sink.

## Interface
- MPT_W, 8, width of Pm, Cm, slot counter and data count
- DATA_W, 8, payload word width

- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- pm  in  MPT_W  payload slots per frame; sampled on sof
- cm  in  MPT_W  data words per frame; sampled on sof
- sof  in  1  start of frame; the sof cycle carries no payload
- valid_in  in  1  payload slot present this cycle
- data_in  in  DATA_W  payload word
- ds_in  in  1  far-end data(1)/stuff(0) indicator for this slot
- data_out  out  DATA_W  extracted data word
- data_valid  out  1  data_out holds a data word
- sof_out  out  1  one-cycle pulse, frame accepted
- eof_out  out  1  one-cycle pulse, last slot (slot Pm) processed
- data_cnt  out  MPT_W  data words passed in the completed frame; valid with eof_out, held until next eof_out
- input_err  out  1  frame parameters illegal (pm = 0 or cm > pm)
- ds_mismatch  out  1  ds_in disagrees with the local decision for this slot
- err_sof_early  out  1  sof arrived before slot Pm
- err_sof_late  out  1  valid_in arrived while no frame is open

## Operation
- States: IDLE (no frame open) and RUN (frame open). Reset enters IDLE.
- sof in any state:
  - latch pm and cm, clear acc, slot counter and running data count, pulse sof_out.
  - Go to RUN if pm != 0 and cm <= pm. Otherwise set input_err and go to IDLE.
  - sof in RUN also pulses err_sof_early. sof has priority over valid_in in the same cycle; that cycle's word is dropped.
- IDLE, valid_in=1, sof=0: pulse err_sof_late and drop the word.
- RUN, valid_in=1: slot j = slot counter + 1.
  - sum = acc + cm, computed MPT_W+1 bits wide.
  - wrap = (sum >= pm).
  - acc <= wrap ? sum - pm : sum.
  - Slot is data iff wrap. This equals (j·Cm mod Pm) < Cm.
  - Data slot: data_out <= data_in, data_valid=1, running count +1.
  - ds_mismatch = (ds_in != wrap).
- RUN, valid_in=0: no state change; data_valid, ds_mismatch and eof_out are 0.
- Slot j = pm: pulse eof_out, load data_cnt with the final count (including this slot), return to IDLE.
- Cm = Pm: every slot is data. Cm = 0: no slot is data, data_cnt = 0.
- input_err holds from the illegal sof until the next legal sof or reset.

## Timing
- All outputs are registered, with 1-cycle latency: the response to the slot, sof or error cycle appears the next cycle.
- sof_out, eof_out, data_valid, ds_mismatch, err_sof_early and err_sof_late are single-cycle pulses. They are 0 in any cycle without a qualifying input in the previous cycle.
- No backpressure: one slot is accepted per valid_in cycle, and valid_in gaps are allowed anywhere in a frame.
- A sof may follow eof_out's slot on the very next cycle without error.
- Reset values: every output is 0, data_cnt = 0, acc = 0, state = IDLE.
- Reset asserted mid-frame: the frame is abandoned and no eof_out is produced. The first valid_in after reset (before any sof) gives err_sof_late.

## Test plan
- pm=8, cm=3, 8 consecutive valid slots with data_in = slot number, ds_in matching -> data_valid on slots 3, 6, 8 with data_out 3, 6, 8; eof_out on slot 8; data_cnt=3; no errors.
- pm=5, cm=5, then pm=5, cm=0, back-to-back frames -> first frame: 5 data words, data_cnt=5; second frame: no data_valid, data_cnt=0; no err_sof_early.
- pm=8, cm=3, ds_in=1 on slot 2 -> ds_mismatch pulse only for slot 2; data stream unchanged.
- pm=8, cm=3, sof after 4 slots -> err_sof_early pulse; new frame restarts at slot 1; old frame gives no eof_out.
- valid_in with no prior sof, then sof with pm=4, cm=6 -> err_sof_late pulse; input_err=1, state stays IDLE; following valid_in gives err_sof_late.
- rst asserted at slot 3 of pm=8, cm=3, released, then a full legal frame -> all outputs 0 during reset; second frame fully correct.
